// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
// Holds operand/opcode/address/instruction types plus the exec FSM encoding.
package instr_register_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned RES_W     = 2 * OPERAND_W;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned COUNT_W   = ADDR_W + 1;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic [ADDR_W-1:0]           address_t;

  // Opcode field is wider than the defined set so undefined encodings exist.
  typedef enum logic [OPCODE_W-1:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU: applies opcode to sign-extended operands, flags
// divide/mod by zero and undefined opcodes.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t                  opcode,
  input  operand_t                 a,
  input  operand_t                 b,
  output logic signed [RES_W-1:0]  res_data_c,
  output logic                     res_err_c
);

  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;

  assign a_ext = RES_W'(a);
  assign b_ext = RES_W'(b);

  always_comb begin
    res_data_c = '0;
    res_err_c  = 1'b0;
    case (opcode)
      ZERO:  res_data_c = '0;
      PASSA: res_data_c = a_ext;
      PASSB: res_data_c = b_ext;
      ADD:   res_data_c = a_ext + b_ext;
      SUB:   res_data_c = a_ext - b_ext;
      MULT:  res_data_c = a_ext * b_ext;
      DIV: begin
        if (b == '0) res_err_c  = 1'b1;
        else         res_data_c = a_ext / b_ext;
      end
      MOD: begin
        if (b == '0) res_err_c  = 1'b1;
        else         res_data_c = a_ext % b_ext;
      end
      default: res_err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a block of instruction register entries, executes
// each one and hands the result out over a valid/ready port.
module instr_exec_unit
  import instr_register_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  address_t                 first_addr,
  input  logic [COUNT_W-1:0]       count,
  output address_t                 read_pointer,
  input  instruction_t             instruction_word,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [RES_W-1:0]  res_data,
  output address_t                 res_addr,
  output logic                     res_err,
  output logic                     busy,
  output logic                     done
);

  exec_state_t             state_q, state_d;
  logic [COUNT_W-1:0]      remaining_q, remaining_d;
  instruction_t            stage_q, stage_d;
  address_t                read_pointer_d;
  logic                    res_valid_d;
  logic signed [RES_W-1:0] res_data_d;
  address_t                res_addr_d;
  logic                    res_err_d;
  logic                    busy_d;
  logic                    done_d;
  logic signed [RES_W-1:0] alu_data_c;
  logic                    alu_err_c;

  instr_alu u_alu (
    .opcode     (stage_q.opcode),
    .a          (stage_q.op_a),
    .b          (stage_q.op_b),
    .res_data_c (alu_data_c),
    .res_err_c  (alu_err_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      stage_q      <= '0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_addr     <= '0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      stage_q      <= stage_d;
      read_pointer <= read_pointer_d;
      res_valid    <= res_valid_d;
      res_data     <= res_data_d;
      res_addr     <= res_addr_d;
      res_err      <= res_err_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state and next-output logic; read_pointer only moves on start or accept.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    stage_d        = stage_q;
    read_pointer_d = read_pointer;
    res_valid_d    = res_valid;
    res_data_d     = res_data;
    res_addr_d     = res_addr;
    res_err_d      = res_err;
    busy_d         = busy;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            read_pointer_d = first_addr;
            remaining_d    = count;
            busy_d         = 1'b1;
            state_d        = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        stage_d    = instruction_word;
        res_addr_d = read_pointer;
        state_d    = EXEC;
      end
      EXEC: begin
        res_data_d  = alu_data_c;
        res_err_d   = alu_err_c;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (res_valid && res_ready) begin
          res_valid_d    = 1'b0;
          remaining_d    = COUNT_W'(remaining_q - 1'b1);
          read_pointer_d = address_t'(read_pointer + 1'b1);
          state_d        = (remaining_q == COUNT_W'(1)) ? FIN : FETCH;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized self-checking bench for instr_exec_unit with an arithmetic
// reference model and a memory model of the instruction register.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    start;
  address_t                first_addr;
  logic [COUNT_W-1:0]      count;
  address_t                read_pointer;
  instruction_t            instruction_word;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [RES_W-1:0] res_data;
  address_t                res_addr;
  logic                    res_err;
  logic                    busy;
  logic                    done;

  instruction_t mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  logic signed [RES_W-1:0] obs_data [$];
  address_t                obs_addr [$];
  logic                    obs_err  [$];
  int  first_valid_cyc, done_cyc, last_acc_cyc, stab_err, busy_err, valid_seen;
  bit  timed_out;
  bit  inject = 1'b0;
  logic done_after;

  instr_exec_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_addr         (res_addr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  // Reference: {err, data} from plain 64-bit signed arithmetic.
  function automatic logic [RES_W:0] ref_exec(input instruction_t ins);
    longint a, b;
    a = longint'(ins.op_a);
    b = longint'(ins.op_b);
    case (ins.opcode)
      ZERO:    return {1'b0, 64'd0};
      PASSA:   return {1'b0, a};
      PASSB:   return {1'b0, b};
      ADD:     return {1'b0, a + b};
      SUB:     return {1'b0, a - b};
      MULT:    return {1'b0, a * b};
      DIV:     return (b == 0) ? {1'b1, 64'd0} : {1'b0, a / b};
      MOD:     return (b == 0) ? {1'b1, 64'd0} : {1'b0, a % b};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  function automatic instruction_t rand_instr();
    instruction_t ins;
    ins.opcode = opcode_t'(OPCODE_W'($urandom_range(9, 0)));
    ins.op_a   = ($urandom_range(1, 0) == 0) ? operand_t'($urandom_range(40, 0)) - 20 : operand_t'($urandom);
    ins.op_b   = ($urandom_range(3, 0) == 0) ? operand_t'(0) : operand_t'($urandom);
    if ($urandom_range(1, 0) == 0 && ins.op_b != 0) ins.op_b = operand_t'($urandom_range(10, 1)) - 5;
    return ins;
  endfunction

  // Drives one block and records every accepted result plus timing/stability observations.
  task automatic run_block(input address_t first, input int cnt, input int smin, input int smax);
    int cyc;
    int stall;
    bit pending;
    logic signed [RES_W-1:0] hd;
    address_t ha, hp;
    logic he;
    obs_data.delete(); obs_addr.delete(); obs_err.delete();
    first_valid_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
    stab_err = 0; busy_err = 0; valid_seen = 0; timed_out = 1'b0;
    pending = 1'b0; stall = 0; hd = '0; ha = '0; hp = '0; he = 1'b0;
    start = 1'b1; first_addr = first; count = COUNT_W'(cnt); res_ready = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inject && cyc == 4) begin
        start = 1'b1; first_addr = address_t'(first + 7); count = COUNT_W'(5);
      end
      if (done) begin done_cyc = cyc; break; end
      if (cnt > 0 && !busy) busy_err++;
      if (res_valid) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!pending) begin
          pending = 1'b1; hd = res_data; ha = res_addr; he = res_err; hp = read_pointer;
          stall = int'($urandom_range(smax, smin));
        end else if (res_data !== hd || res_addr !== ha || res_err !== he || read_pointer !== hp) begin
          stab_err++;
        end
        if (stall == 0) begin
          res_ready = 1'b1; pending = 1'b0; last_acc_cyc = cyc;
          obs_data.push_back(res_data); obs_addr.push_back(res_addr); obs_err.push_back(res_err);
        end else begin
          res_ready = 1'b0; stall--;
        end
      end else begin
        if (pending) stab_err++;
        pending = 1'b0;
        res_ready = 1'($urandom_range(1, 0));
      end
      if (cyc > 3000) begin timed_out = 1'b1; break; end
    end
    start = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; res_ready = 1'b0; first_addr = '0; count = '0;
    repeat (3) @(negedge clk);
    vectors++; if (read_pointer !== '0) begin miscompares++; $display("FAIL reset_read_pointer: got %0d exp 0", read_pointer); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
    vectors++; if (res_data !== '0) begin miscompares++; $display("FAIL reset_res_data: got %0d exp 0", res_data); end
    vectors++; if (res_addr !== '0) begin miscompares++; $display("FAIL reset_res_addr: got %0d exp 0", res_addr); end
    vectors++; if ({res_err, busy, done} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b exp 000", {res_err, busy, done}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed;
    logic signed [RES_W-1:0] exp_d [5];
    logic                    exp_e [5];
    mem[3] = '{opcode: ADD, op_a: 32'sd5, op_b: -32'sd7};
    run_block(5'd3, 1, 0, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL add_timeout: got %b exp 0", timed_out); end
    vectors++; if (obs_data.size() !== 1) begin miscompares++; $display("FAIL add_count: got %0d exp 1", obs_data.size()); end
    else begin
      vectors++; if (obs_data[0] !== -64'sd2) begin miscompares++; $display("FAIL add_data: got %0d exp -2", obs_data[0]); end
      vectors++; if (obs_addr[0] !== 5'd3) begin miscompares++; $display("FAIL add_addr: got %0d exp 3", obs_addr[0]); end
      vectors++; if (obs_err[0] !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b exp 0", obs_err[0]); end
    end
    vectors++; if (first_valid_cyc !== 3) begin miscompares++; $display("FAIL add_valid_latency: got %0d exp 3", first_valid_cyc); end
    vectors++; if (done_cyc !== last_acc_cyc + 2) begin miscompares++; $display("FAIL add_done_latency: got %0d exp %0d", done_cyc, last_acc_cyc + 2); end
    vectors++; if (done_after !== 1'b0) begin miscompares++; $display("FAIL add_done_width: got %b exp 0", done_after); end

    mem[10] = '{opcode: MULT, op_a: 32'sh7FFFFFFF, op_b: 32'sd2};
    mem[11] = '{opcode: DIV,  op_a: -32'sd7, op_b: 32'sd2};
    mem[12] = '{opcode: MOD,  op_a: -32'sd7, op_b: 32'sd2};
    mem[13] = '{opcode: DIV,  op_a: 32'sd9,  op_b: 32'sd0};
    mem[14].opcode = opcode_t'(4'd12); mem[14].op_a = 32'sd1; mem[14].op_b = 32'sd1;
    exp_d[0] = 64'sh00000000FFFFFFFE; exp_e[0] = 1'b0;
    exp_d[1] = -64'sd3;               exp_e[1] = 1'b0;
    exp_d[2] = -64'sd1;               exp_e[2] = 1'b0;
    exp_d[3] = 64'sd0;                exp_e[3] = 1'b1;
    exp_d[4] = 64'sd0;                exp_e[4] = 1'b1;
    run_block(5'd10, 5, 0, 2);
    vectors++; if (obs_data.size() !== 5) begin miscompares++; $display("FAIL ops_count: got %0d exp 5", obs_data.size()); end
    else for (int i = 0; i < 5; i++) begin
      vectors++; if (obs_data[i] !== exp_d[i] || obs_err[i] !== exp_e[i]) begin
        miscompares++; $display("FAIL ops[%0d]: got %0d/err %b exp %0d/err %b", i, obs_data[i], obs_err[i], exp_d[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [RES_W:0] e;
    for (int i = 0; i < 4; i++) mem[address_t'(30 + i)] = rand_instr();
    run_block(5'd30, 4, 0, 3);
    vectors++; if (timed_out !== 1'b0 || busy_err !== 0) begin miscompares++; $display("FAIL wrap_busy: got timeout %b busy_err %0d exp 0 0", timed_out, busy_err); end
    vectors++; if (obs_addr.size() !== 4) begin miscompares++; $display("FAIL wrap_count: got %0d exp 4", obs_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      e = ref_exec(mem[address_t'(30 + i)]);
      vectors++; if (obs_addr[i] !== address_t'(30 + i) || obs_data[i] !== e[RES_W-1:0] || obs_err[i] !== e[RES_W]) begin
        miscompares++; $display("FAIL wrap[%0d]: got addr %0d %0d/%b exp addr %0d %0d/%b", i, obs_addr[i], obs_data[i], obs_err[i], address_t'(30 + i), $signed(e[RES_W-1:0]), e[RES_W]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [RES_W:0] e;
    for (int i = 20; i < 23; i++) mem[i] = rand_instr();
    run_block(5'd20, 3, 5, 5);
    vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL bp_stability: got %0d unstable cycles exp 0", stab_err); end
    vectors++; if (last_acc_cyc !== 24) begin miscompares++; $display("FAIL bp_last_accept: got cycle %0d exp 24", last_acc_cyc); end
    vectors++; if (obs_data.size() !== 3) begin miscompares++; $display("FAIL bp_count: got %0d exp 3", obs_data.size()); end
    else for (int i = 0; i < 3; i++) begin
      e = ref_exec(mem[20 + i]);
      vectors++; if (obs_data[i] !== e[RES_W-1:0] || obs_err[i] !== e[RES_W] || obs_addr[i] !== address_t'(20 + i)) begin
        miscompares++; $display("FAIL bp[%0d]: got %0d/%b exp %0d/%b", i, obs_data[i], obs_err[i], $signed(e[RES_W-1:0]), e[RES_W]);
      end
    end
  endtask

  task automatic test_count_zero;
    run_block(5'd7, 0, 0, 0);
    vectors++; if (valid_seen !== 0) begin miscompares++; $display("FAIL zero_valid: got %0d valid cycles exp 0", valid_seen); end
    vectors++; if (done_cyc !== 2) begin miscompares++; $display("FAIL zero_done_latency: got %0d exp 2", done_cyc); end
    vectors++; if (done_after !== 1'b0) begin miscompares++; $display("FAIL zero_done_width: got %b exp 0", done_after); end
  endtask

  task automatic test_start_ignored;
    logic signed [RES_W-1:0] ref_d [$];
    address_t                ref_a [$];
    logic [RES_W:0]          e;
    for (int i = 16; i < 20; i++) mem[i] = rand_instr();
    run_block(5'd16, 4, 0, 2);
    ref_d = obs_data; ref_a = obs_addr;
    inject = 1'b1;
    run_block(5'd16, 4, 0, 2);
    inject = 1'b0;
    vectors++; if (obs_data.size() !== 4 || ref_d.size() !== 4) begin miscompares++; $display("FAIL ignore_count: got %0d and %0d exp 4", obs_data.size(), ref_d.size()); end
    else for (int i = 0; i < 4; i++) begin
      e = ref_exec(mem[16 + i]);
      vectors++; if (obs_data[i] !== ref_d[i] || obs_addr[i] !== ref_a[i] || obs_data[i] !== e[RES_W-1:0]) begin
        miscompares++; $display("FAIL ignore[%0d]: got %0d@%0d exp %0d@%0d", i, obs_data[i], obs_addr[i], $signed(e[RES_W-1:0]), address_t'(16 + i));
      end
    end
  endtask

  task automatic test_random;
    address_t f;
    int       n;
    logic [RES_W:0] e;
    for (int it = 0; it < 21; it++) begin
      for (int j = 0; j < DEPTH; j++) mem[j] = rand_instr();
      f = address_t'($urandom_range(DEPTH - 1, 0));
      n = (it == 20) ? DEPTH : int'($urandom_range(6, 1));
      run_block(f, n, 0, 3);
      vectors++; if (timed_out !== 1'b0 || obs_data.size() !== n || busy_err !== 0) begin
        miscompares++; $display("FAIL rand%0d_block: got %0d results timeout %b busy_err %0d exp %0d 0 0", it, obs_data.size(), timed_out, busy_err, n);
      end else for (int i = 0; i < n; i++) begin
        e = ref_exec(mem[address_t'(f + i)]);
        vectors++; if (obs_addr[i] !== address_t'(f + i) || obs_data[i] !== e[RES_W-1:0] || obs_err[i] !== e[RES_W]) begin
          miscompares++; $display("FAIL rand%0d[%0d]: got %0d %0d/%b exp %0d %0d/%b", it, i, obs_addr[i], obs_data[i], obs_err[i], address_t'(f + i), $signed(e[RES_W-1:0]), e[RES_W]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int waited;
    bit done_seen;
    logic [RES_W:0] e;
    for (int i = 5; i < 10; i++) mem[i] = rand_instr();
    @(negedge clk);
    start = 1'b1; first_addr = 5'd5; count = COUNT_W'(3); res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; waited = 1;
    while (!res_valid && waited < 20) begin @(negedge clk); waited++; end
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_reach_out: got %b exp 1", res_valid); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({res_valid, busy, done, res_err} !== 4'b0000) begin miscompares++; $display("FAIL rstmid_flags: got %b exp 0000", {res_valid, busy, done, res_err}); end
    vectors++; if (res_data !== '0 || res_addr !== '0 || read_pointer !== '0) begin
      miscompares++; $display("FAIL rstmid_regs: got data %0d addr %0d rp %0d exp 0 0 0", res_data, res_addr, read_pointer);
    end
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (done) done_seen = 1'b1; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) done_seen = 1'b1; end
    vectors++; if (done_seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b exp 0", done_seen); end
    run_block(5'd8, 2, 0, 1);
    vectors++; if (first_valid_cyc !== 3 || obs_data.size() !== 2) begin
      miscompares++; $display("FAIL rstmid_restart: got latency %0d results %0d exp 3 2", first_valid_cyc, obs_data.size());
    end else for (int i = 0; i < 2; i++) begin
      e = ref_exec(mem[8 + i]);
      vectors++; if (obs_data[i] !== e[RES_W-1:0] || obs_err[i] !== e[RES_W]) begin
        miscompares++; $display("FAIL rstmid[%0d]: got %0d/%b exp %0d/%b", i, obs_data[i], obs_err[i], $signed(e[RES_W-1:0]), e[RES_W]);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) mem[j] = '0;
    test_reset();
    test_directed();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
